// File: rtl/dds_ctrl_pkg.sv
// Shared constants for the DDS sweep controller.
// State encoding and sweep mode codes.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DWELL   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;

  // Reserved code 11 behaves as a single sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: load, count down, flag last count.
// expire marks the cycle before the final (advance) cycle.
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: single, sawtooth and
// triangle sweeps of the Step word with per-step dwell.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int FW_W    = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FW_W-1:0]    start_fw,
  input  logic [FW_W-1:0]    stop_fw,
  input  logic [FW_W-1:0]    incr_fw,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  input  logic [FW_W-1:0]    phase_in,
  output logic [FW_W-1:0]    Step,
  output logic [FW_W-1:0]    phase,
  output logic               update,
  output logic               busy,
  output logic               done
);

  state_t state, nstate;

  logic [FW_W-1:0]    start_r, stop_r, incr_r;
  logic [DWELL_W-1:0] dwl_r;
  logic [1:0]         mode_r;
  logic               dir_dn;

  logic               go, expire, at_top, fin;
  logic [FW_W:0]      sum, dif;
  logic               dn_hit;
  logic [FW_W-1:0]    up_val, dn_val;
  logic [DWELL_W-1:0] dw_in, ld_cnt;

  logic               load, dir_nxt, done_nxt;
  logic [FW_W-1:0]    nxt;

  assign go     = (state == ST_IDLE) && start && !abort;
  assign dw_in  = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign ld_cnt = ((state == ST_IDLE) ? dw_in : dwl_r)
                - DWELL_W'(1);

  // Extra bit catches carry/borrow so the sweep never wraps.
  assign sum    = {1'b0, Step} + {1'b0, incr_r};
  assign up_val = (sum[FW_W] || sum[FW_W-1:0] >= stop_r)
                ? stop_r : sum[FW_W-1:0];
  assign dif    = {1'b0, Step} - {1'b0, incr_r};
  assign dn_hit = dif[FW_W] || dif[FW_W-1:0] <= start_r;
  assign dn_val = dn_hit ? start_r : dif[FW_W-1:0];

  assign at_top = !dir_dn && (Step >= stop_r);
  assign fin    = at_top && (mode_r == MODE_SINGLE);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: begin
        if (go) begin
          nstate = (dw_in == DWELL_W'(1))
                 ? ST_ADVANCE : ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (abort)       nstate = ST_IDLE;
        else if (expire) nstate = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (abort || fin) nstate = ST_IDLE;
        else nstate = (dwl_r == DWELL_W'(1))
                    ? ST_ADVANCE : ST_DWELL;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    nxt      = Step;
    dir_nxt  = dir_dn;
    done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          load    = 1'b1;
          nxt     = start_fw;
          dir_nxt = 1'b0;
        end
      end
      ST_ADVANCE: begin
        if (!abort) begin
          if (fin) begin
            done_nxt = 1'b1;
          end else if (at_top && mode_r == MODE_REPEAT) begin
            load = 1'b1;
            nxt  = start_r;
          end else if (at_top || dir_dn) begin
            load    = 1'b1;
            nxt     = dn_val;
            dir_nxt = !dn_hit;
          end else begin
            load = 1'b1;
            nxt  = up_val;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Step    <= '0;
      phase   <= '0;
      update  <= 1'b0;
      done    <= 1'b0;
      dir_dn  <= 1'b0;
      start_r <= '0;
      stop_r  <= '0;
      incr_r  <= '0;
      dwl_r   <= '0;
      mode_r  <= MODE_SINGLE;
    end else begin
      update <= load;
      done   <= done_nxt;
      dir_dn <= dir_nxt;
      if (load) Step <= nxt;
      if (go) begin
        phase   <= phase_in;
        start_r <= start_fw;
        stop_r  <= stop_fw;
        incr_r  <= incr_fw;
        dwl_r   <= dw_in;
        mode_r  <= norm_mode(mode);
      end
    end
  end

  dds_dwell_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(ld_cnt),
    .en      (state == ST_DWELL),
    .expire  (expire)
  );

endmodule
